// File: rtl/l2_req_arbiter_pkg.sv
// rtl/l2_req_arbiter_pkg.sv - shared types and constants for the L2 request arbiter
package l2_req_arbiter_pkg;

    localparam int L2_ADDR_W = 28;
    localparam int L2_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/l2_req_arbiter_if.sv
// rtl/l2_req_arbiter_if.sv - L1 I/D miss ports and L2 request port bundle
interface l2_req_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_ready;
    logic [DATA_W-1:0] l2_rdata;

    // Arbiter side: serves the L1 requesters, drives the L2 request.
    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_ready, i_rdata,
        input  d_read, d_write, d_addr, d_wdata,
        output d_ready, d_rdata,
        output l2_read, l2_write, l2_addr, l2_wdata,
        input  l2_ready, l2_rdata
    );

    // Environment side: L1 requesters plus the L2 cache.
    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_ready, i_rdata,
        output d_read, d_write, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  l2_read, l2_write, l2_addr, l2_wdata,
        output l2_ready, l2_rdata
    );

endinterface

// File: rtl/l2_req_arbiter_rr_pick2.sv
// rtl/l2_req_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       any_o
);

    // On a tie the port that did not win last goes next; otherwise the lone requester.
    always_comb begin
        any_o   = |req_i;
        grant_o = (req_i == 2'b11) ? ~last_i : req_i[1];
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - round-robin sharing of the L2 request port between L1 I and D
module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int ADDR_W  = L2_ADDR_W,
    parameter int DATA_W  = L2_DATA_W,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_req_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] grant_cnt_i,
    output logic [CNT_W-1:0] grant_cnt_d,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_i_q, cnt_i_d;
    logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        req;
    logic              pick_id;
    logic              pick_any;

    assign req = {bus.d_read | bus.d_write, bus.i_read | bus.i_write};

    rr_pick2 u_pick (
        .req_i   (req),
        .last_i  (last_grant_q),
        .grant_o (pick_id),
        .any_o   (pick_any)
    );

    // Read data is a straight pass-through; only meaningful alongside ready.
    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;
    assign bus.l2_addr  = addr_q;
    assign bus.l2_wdata = wdata_q;
    assign grant_cnt_i  = cnt_i_q;
    assign grant_cnt_d  = cnt_d_q;
    assign timeout_err  = timeout_q;

    // Next-state, latching of the winner, completion handling and watchdog.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_i_d      = cnt_i_q;
        cnt_d_d      = cnt_d_q;
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        bus.i_ready  = 1'b0;
        bus.d_ready  = 1'b0;
        bus.l2_read  = 1'b0;
        bus.l2_write = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_id;
                    // read&write together is treated as a write
                    if (pick_id == PORT_D) begin
                        op_wr_d = bus.d_write;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        op_wr_d = bus.i_write;
                        addr_d  = bus.i_addr;
                        wdata_d = bus.i_wdata;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus.l2_read  = ~op_wr_q;
                bus.l2_write = op_wr_q;
                // The watchdog only flags; the transaction keeps waiting for L2.
                if (wdog_q >= WD_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                end
                if (wdog_q != WD_W'(TIMEOUT)) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
                if (bus.l2_ready) begin
                    if (grant_id_q == PORT_D) begin
                        bus.d_ready = 1'b1;
                        if (cnt_d_q != '1) cnt_d_d = cnt_d_q + CNT_W'(1);
                    end else begin
                        bus.i_ready = 1'b1;
                        if (cnt_i_q != '1) cnt_i_d = cnt_i_q + CNT_W'(1);
                    end
                    last_grant_d = grant_id_q;
                    wdog_d       = '0;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // One dead cycle so L2 re-arms its single-cycle ready logic.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_D;
            grant_id_q   <= PORT_I;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_i_q      <= '0;
            cnt_d_q      <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_i_q      <= cnt_i_d;
            cnt_d_q      <= cnt_d_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb/tb_l2_req_arbiter.sv - scoreboard bench for the L2 request arbiter
module tb_l2_req_arbiter;
    import l2_req_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int CW = 16;

    typedef struct packed {
        logic          port;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk;
    logic rst_n;
    logic [CW-1:0] grant_cnt_i;
    logic [CW-1:0] grant_cnt_d;
    logic timeout_err;

    l2_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    l2_req_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_cnt_i (grant_cnt_i),
        .grant_cnt_d (grant_cnt_d),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    txn_t iq[$];
    txn_t dq[$];
    txn_t l2_exp[$];
    txn_t cur;
    txn_t ti;
    txn_t td;
    logic cur_valid = 1'b0;
    logic i_act = 1'b0, d_act = 1'b0;
    logic i_done = 1'b0, d_done = 1'b0;
    logic rsp_en = 1'b1;
    logic inject_rdy = 1'b0;
    logic chk_gap = 1'b0;
    logic gap_armed = 1'b0;
    logic drain_pend = 1'b0;
    logic req_prev = 1'b0;
    logic req_now;
    int   lat = 4;
    int   low_cnt = 0;
    int   wait_cnt = 0;
    int   m_cnt_i = 0, m_cnt_d = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return (a == 28'h0000123) ? 128'hA5 : {a, 4'h0, 96'hC0DE_0000_0000_0000_0000_BEEF};
    endfunction

    // Queue a request on one port and its expected L2 transaction, in expected grant order.
    task automatic push_txn(input logic port, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        txn_t t;
        t = '{port: port, rd: rd, wr: wr, addr: addr, wdata: wdata};
        if (port == PORT_D) dq.push_back(t);
        else iq.push_back(t);
        l2_exp.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iq.delete();
        dq.delete();
        l2_exp.delete();
        m_cnt_i = 0;
        m_cnt_d = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((l2_exp.size() != 0 || iq.size() != 0 || dq.size() != 0 || i_act || d_act)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_budget", 128'(n < budget), 128'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.l2_read || bus.l2_write) && n < budget);
        check("wait_req_budget", 128'(n < budget), 128'(1));
    endtask

    // I-side requester: holds the request until its ready, drops it in DRAIN.
    initial begin
        bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                i_act = 1'b0; i_done = 1'b0; bus.i_read = 1'b0; bus.i_write = 1'b0;
            end else if (i_done) begin
                i_done = 1'b0; i_act = 1'b0; bus.i_read = 1'b0; bus.i_write = 1'b0;
            end else if (!i_act && iq.size() != 0) begin
                ti = iq.pop_front();
                bus.i_read = ti.rd; bus.i_write = ti.wr; bus.i_addr = ti.addr; bus.i_wdata = ti.wdata;
                i_act = 1'b1;
            end
        end
    end

    // D-side requester.
    initial begin
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                d_act = 1'b0; d_done = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
            end else if (d_done) begin
                d_done = 1'b0; d_act = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
            end else if (!d_act && dq.size() != 0) begin
                td = dq.pop_front();
                bus.d_read = td.rd; bus.d_write = td.wr; bus.d_addr = td.addr; bus.d_wdata = td.wdata;
                d_act = 1'b1;
            end
        end
    end

    // L2 model: answers a pending request after lat cycles with a one-cycle ready.
    initial begin
        bus.l2_ready = 1'b0;
        bus.l2_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                wait_cnt = 0; bus.l2_ready = 1'b0;
            end else if (bus.l2_ready) begin
                bus.l2_ready = 1'b0; wait_cnt = 0;
            end else if (inject_rdy) begin
                bus.l2_ready = 1'b1;
            end else if (rsp_en && (bus.l2_read || bus.l2_write)) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    bus.l2_ready = 1'b1;
                    bus.l2_rdata = rd_of(bus.l2_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: compare L2 requests and ready pulses against the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0; drain_pend = 1'b0; low_cnt = 0; cur_valid = 1'b0; gap_armed = 1'b0;
        end else begin
            req_now = bus.l2_read | bus.l2_write;
            if (drain_pend) begin
                check("drain_low", 128'(req_now), 128'(0));
                check("cnt_i", 128'(grant_cnt_i), 128'(m_cnt_i));
                check("cnt_d", 128'(grant_cnt_d), 128'(m_cnt_d));
                drain_pend = 1'b0;
            end
            if (req_now && !req_prev) begin
                if (chk_gap && gap_armed) check("gap", 128'(low_cnt), 128'(2));
                gap_armed = 1'b0;
                if (l2_exp.size() == 0) begin
                    check("l2_unexpected", 128'(l2_exp.size()), 128'(1));
                end else begin
                    cur = l2_exp.pop_front();
                    cur_valid = 1'b1;
                    check("l2_write", 128'(bus.l2_write), 128'(cur.wr));
                    check("l2_read", 128'(bus.l2_read), 128'(cur.rd & ~cur.wr));
                    check("l2_addr", 128'(bus.l2_addr), 128'(cur.addr));
                    check("l2_wdata", bus.l2_wdata, cur.wdata);
                end
            end else if (req_now && cur_valid) begin
                check("l2_hold_addr", 128'(bus.l2_addr), 128'(cur.addr));
            end
            if (req_now) low_cnt = 0;
            else low_cnt++;
            if (bus.i_ready || bus.d_ready) begin
                if (!cur_valid) begin
                    check("rdy_unexpected", 128'({bus.i_ready, bus.d_ready}), 128'(0));
                end else begin
                    check("rdy_port", 128'({bus.i_ready, bus.d_ready}),
                          (cur.port == PORT_D) ? 128'(2'b01) : 128'(2'b10));
                    check("rdata", (cur.port == PORT_D) ? bus.d_rdata : bus.i_rdata, rd_of(cur.addr));
                    if (cur.port == PORT_D) begin m_cnt_d++; d_done = 1'b1; end
                    else begin m_cnt_i++; i_done = 1'b1; end
                    cur_valid = 1'b0;
                    drain_pend = 1'b1;
                    gap_armed = 1'b1;
                end
            end
            req_prev = req_now;
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_l2_read", 128'(bus.l2_read), 128'(0));
        check("rst_l2_write", 128'(bus.l2_write), 128'(0));
        check("rst_l2_addr", 128'(bus.l2_addr), 128'(0));
        check("rst_l2_wdata", bus.l2_wdata, 128'(0));
        check("rst_ready", 128'({bus.i_ready, bus.d_ready}), 128'(0));
        check("rst_cnt_i", 128'(grant_cnt_i), 128'(0));
        check("rst_cnt_d", 128'(grant_cnt_d), 128'(0));
        check("rst_timeout", 128'(timeout_err), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Lone I read.
        @(negedge clk);
        lat = 4;
        push_txn(PORT_I, 1'b1, 1'b0, 28'h0000123, 128'h0);
        wait_idle(200);
        check("t1_cnt_i", 128'(grant_cnt_i), 128'(1));
        check("t1_cnt_d", 128'(grant_cnt_d), 128'(0));

        // Tie after reset: I first, then D write.
        do_reset();
        lat = 2;
        @(negedge clk);
        push_txn(PORT_I, 1'b1, 1'b0, 28'h0000200, 128'h0);
        push_txn(PORT_D, 1'b0, 1'b1, 28'h0000040, 128'h5A);
        wait_idle(200);
        check("t2_cnt_i", 128'(grant_cnt_i), 128'(1));
        check("t2_cnt_d", 128'(grant_cnt_d), 128'(1));

        // Continuous requests on both ports alternate.
        do_reset();
        lat = 1;
        chk_gap = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            push_txn(PORT_I, 1'b1, 1'b0, 28'h0000300 + AW'(k), 128'h0);
            push_txn(PORT_D, ~k[0], k[0], 28'h0000400 + AW'(k), 128'h1000 + DW'(k));
        end
        wait_idle(400);
        chk_gap = 1'b0;
        check("t3_cnt_i", 128'(grant_cnt_i), 128'(3));
        check("t3_cnt_d", 128'(grant_cnt_d), 128'(3));

        // D read and write together -> write.
        push_txn(PORT_D, 1'b1, 1'b1, 28'h0000077, 128'h1234);
        wait_idle(200);

        // Watchdog with L2 silent.
        rsp_en = 1'b0;
        push_txn(PORT_D, 1'b1, 1'b0, 28'h0000099, 128'h0);
        wait_req(50);
        check("t5_err_early", 128'(timeout_err), 128'(0));
        repeat (7) @(negedge clk);
        check("t5_err_before", 128'(timeout_err), 128'(0));
        @(negedge clk);
        check("t5_err_set", 128'(timeout_err), 128'(1));
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 128'(timeout_err), 128'(1));
        lat = 3;
        rsp_en = 1'b1;
        wait_idle(200);
        check("t5_err_after", 128'(timeout_err), 128'(1));

        // l2_ready while IDLE is ignored.
        inject_rdy = 1'b1;
        @(negedge clk);
        inject_rdy = 1'b0;
        check("t6_l2_ready_seen", 128'(bus.l2_ready), 128'(1));
        check("t6_no_ready", 128'({bus.i_ready, bus.d_ready}), 128'(0));
        @(negedge clk);
        check("t6_cnt_i", 128'(grant_cnt_i), 128'(m_cnt_i));
        check("t6_cnt_d", 128'(grant_cnt_d), 128'(m_cnt_d));

        // Reset while BUSY.
        rsp_en = 1'b0;
        push_txn(PORT_I, 1'b1, 1'b0, 28'h0000055, 128'h0);
        wait_req(50);
        #2;
        rst_n = 1'b0;
        iq.delete();
        dq.delete();
        l2_exp.delete();
        m_cnt_i = 0;
        m_cnt_d = 0;
        #1;
        check("t7_l2_read", 128'(bus.l2_read), 128'(0));
        check("t7_l2_write", 128'(bus.l2_write), 128'(0));
        check("t7_l2_addr", 128'(bus.l2_addr), 128'(0));
        check("t7_cnt_i", 128'(grant_cnt_i), 128'(0));
        check("t7_cnt_d", 128'(grant_cnt_d), 128'(0));
        check("t7_timeout", 128'(timeout_err), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_en = 1'b1;
        lat = 2;
        @(negedge clk);
        push_txn(PORT_I, 1'b1, 1'b0, 28'h0000066, 128'h0);
        wait_idle(200);
        check("t7_post_cnt_i", 128'(grant_cnt_i), 128'(1));
        check("t7_post_cnt_d", 128'(grant_cnt_d), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
